bp_reset_sequencer: RTL
=======================

Name: bp_reset_sequencer

Overview:
- Parametrised boot/reset sequencer for the FPGA top level. It replaces ad-hoc per-block reset wiring.
- Holds N downstream reset channels asserted until DRAM calibration completes, then releases them one at a time in index order (e.g. 0=DRAM-side, 1=FPGA host, 2=core).
- Each release is followed by a programmable delay and an optional per-channel ready acknowledge.
- Supervises calibration and acknowledges with a timeout and a sticky error. Supports software-requested re-sequencing.

Parameters:
- num_channels_p, 3, number of reset channels (1..16).
- hold_cycles_p, 8, minimum cycles all resets stay asserted after reset_i or soft_reset_i.
- stage_delay_p, 16, cycles between a channel's release and the earliest advance to the next channel (>=1).
- timeout_p, 2**20, maximum cycles spent waiting for calibration, or for any single ack.
- ack_mask_p, {num_channels_p{1'b1}}, bit k=1: channel k must see ack_i[k] before advancing.
- led_half_period_p, 2**24, heartbeat toggle period in cycles (optional feature only).

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- calib_done_i  in  1  asynchronous DRAM init_calib_complete; 2-flop synchronised internally.
- soft_reset_i  in  1  single-cycle request to re-run the full sequence.
- ack_i  in  num_channels_p  per-channel ready, synchronous to clk_i.
- reset_o  out  num_channels_p  active-high per-channel reset, registered.
- busy_o  out  1  sequence in progress.
- done_o  out  1  all channels released.
- error_o  out  1  sticky timeout/calibration-loss flag.
- stage_o  out  `BSG_SAFE_CLOG2(num_channels_p)  index of the channel currently being released.
- heartbeat_o  out  1  status LED.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, ports clk_i/reset_i.
  - All outputs are registered.
  - reset_i values: reset_o all 1, busy_o 1, done_o 0, error_o 0, stage_o 0, heartbeat_o 0, state HOLD, counters 0.
- States: HOLD, WAIT_CALIB, RELEASE, RUN, ERROR.
- Priority of events: reset_i > soft_reset_i > all other events.
- soft_reset_i:
  - Accepted in any state, including ERROR and mid-RELEASE.
  - Next cycle: state HOLD, reset_o all 1, error_o 0, done_o 0, busy_o 1, stage_o 0, counters cleared.
- HOLD:
  - Stays exactly hold_cycles_p cycles, then moves to WAIT_CALIB.
  - calib_done_i is ignored during HOLD.
- WAIT_CALIB:
  - The timeout counter increments each cycle.
  - If synchronised calib is seen high: go to RELEASE with stage 0. reset_o[0] is 0 on the following cycle.
  - If the counter reaches timeout_p-1 with calib low: go to ERROR.
  - If calib is seen in the same cycle as the timeout, calib wins.
  - calib_done_i latency to the state machine is 2 cycles (synchroniser).
- RELEASE(k):
  - reset_o[k] cleared on entry. reset_o[j<k] stay 0, reset_o[j>k] stay 1.
  - The delay counter runs for stage_delay_p cycles.
  - After that, advance when ack_mask_p[k]==0 or ack_i[k]==1.
  - Advance means: k<num_channels_p-1 → RELEASE(k+1), with reset_o[k+1] falling on the edge after the qualifying cycle. k==num_channels_p-1 → RUN.
  - Minimum spacing between consecutive releases is exactly stage_delay_p cycles.
  - The timeout counter restarts at each RELEASE entry. Reaching timeout_p-1 while still waiting for ack → ERROR.
- RUN:
  - done_o 1, busy_o 0, reset_o all 0.
  - Synchronised calib low → ERROR.
- ERROR:
  - reset_o all 1, error_o 1, busy_o 0, done_o 0.
  - Stays in ERROR until reset_i or soft_reset_i.
  - stage_o holds the stage that failed. It reads 0 for a calibration timeout and for a calibration loss in RUN.
- ack_i bits for channels not yet released, or masked in ack_mask_p, are ignored.
- Counters are sized `BSG_SAFE_CLOG2(max+1)` and saturate rather than wrap.
- num_channels_p==1: after stage_delay_p and ack, RELEASE(0) goes directly to RUN.

Optional Feature:
- Macro BP_RESET_SEQ_HEARTBEAT_EN.
- Defined:
  - In RUN, heartbeat_o toggles every led_half_period_p cycles, starting at 0 on RUN entry.
  - Solid 1 in ERROR, 0 otherwise.
- Undefined: heartbeat_o tied 0, no heartbeat counter is instantiated, led_half_period_p is unused.

Test Plan:
Common setup unless stated: num_channels_p=3, hold=8, delay=4, timeout=100, mask=3'b111.
1. Nominal: calib_done_i=1 from start, ack_i=3'b111 → reset_o[0] falls at cycle T. reset_o[1] at T+4, reset_o[2] at T+8. done_o rises at T+12, busy_o falls at T+12, error_o stays 0.
2. Calibration timeout: calib_done_i=0 → after 8 hold cycles plus 100 wait cycles: error_o=1, reset_o=3'b111, stage_o=0. A soft_reset_i pulse clears error_o on the next cycle.
3. Ack stall: ack_i[1]=0 for 20 cycles after reset_o[1] falls, then ack_i[1]=1 → reset_o[2] falls exactly 1 cycle after ack_i[1] is sampled high. With mask=3'b101 and ack_i[1]=0, reset_o[2] falls 4 cycles after reset_o[1].
4. Calibration loss: reach RUN, then drop calib_done_i → 2 cycles later state is ERROR. Next cycle: reset_o=3'b111, error_o=1, done_o=0, stage_o=0.
5. Mid-sequence soft reset: pulse soft_reset_i while in RELEASE(1) → next cycle reset_o=3'b111, stage_o=0, busy_o=1. The full sequence then repeats with the scenario 1 timing. soft_reset_i and reset_i together → reset values.
6. With BP_RESET_SEQ_HEARTBEAT_EN defined and led_half_period_p=5 → in RUN, heartbeat_o toggles 0→1 at cycle 5 and 1→0 at cycle 10; in ERROR it is constant 1. Without the macro, heartbeat_o is always 0.

Source files
------------

// File: rtl/bp_reset_sequencer.sv
// bp_reset_sequencer: staged boot reset release gated on DRAM calibration and per-channel acks.
// Define BP_RESET_SEQ_HEARTBEAT_EN to drive a heartbeat LED on heartbeat_o.
module bp_reset_sequencer #(
  parameter int num_channels_p = 3,
  parameter int hold_cycles_p = 8,
  parameter int stage_delay_p = 16,
  parameter int timeout_p = 2**20,
  parameter logic [num_channels_p-1:0] ack_mask_p = {num_channels_p{1'b1}},
  parameter int led_half_period_p = 2**24
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic calib_done_i,
  input  logic soft_reset_i,
  input  logic [num_channels_p-1:0] ack_i,
  output logic [num_channels_p-1:0] reset_o,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  output logic [((num_channels_p > 1) ? $clog2(num_channels_p) : 1)-1:0] stage_o,
  output logic heartbeat_o
);
  localparam int stage_w_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int cnt_max_lp = (hold_cycles_p > stage_delay_p) ? hold_cycles_p : stage_delay_p;
  localparam int cnt_w_lp = $clog2(cnt_max_lp + 1);
  localparam int to_w_lp = $clog2(timeout_p + 1);
  localparam logic [2:0] hold_s = 3'd0;
  localparam logic [2:0] wait_s = 3'd1;
  localparam logic [2:0] rel_s = 3'd2;
  localparam logic [2:0] run_s = 3'd3;
  localparam logic [2:0] err_s = 3'd4;
  if (num_channels_p < 1 || num_channels_p > 16 || hold_cycles_p < 1 || stage_delay_p < 1 ||
      timeout_p < 1 || led_half_period_p < 1) begin : g_bad_params
    $error("bp_reset_sequencer: illegal parameter value");
  end
  logic [2:0] state_q, state_d;
  logic [stage_w_lp-1:0] stage_q, stage_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d, cnt_inc;
  logic [to_w_lp-1:0] to_q, to_d, to_inc;
  logic [1:0] sync_q;
  logic [num_channels_p-1:0] rel_mask;
  logic calib, delay_ok, ack_ok, last, to_hit;
  assign calib = sync_q[1];
  assign delay_ok = cnt_q == cnt_w_lp'(stage_delay_p - 1);
  assign ack_ok = !ack_mask_p[stage_q] || ack_i[stage_q];
  assign last = stage_q == stage_w_lp'(num_channels_p - 1);
  assign to_hit = to_q == to_w_lp'(timeout_p - 1);
  assign cnt_inc = (cnt_q == cnt_w_lp'(cnt_max_lp)) ? cnt_q : cnt_q + 1'b1;
  assign to_inc = to_hit ? to_q : to_q + 1'b1;
  // channels above the one being released stay in reset
  assign rel_mask = {num_channels_p{1'b1}} << (stage_d + 32'd1);
  assign stage_o = stage_q;
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d = cnt_q;
    to_d = to_q;
    case (state_q)
      hold_s: begin
        cnt_d = cnt_inc;
        if (cnt_q == cnt_w_lp'(hold_cycles_p - 1)) begin
          state_d = wait_s;
          cnt_d = '0;
        end
      end
      wait_s: begin
        to_d = to_inc;
        if (calib) begin
          state_d = rel_s;
          stage_d = '0;
          cnt_d = '0;
          to_d = '0;
        end else if (to_hit) begin
          state_d = err_s;
          stage_d = '0;
        end
      end
      rel_s: begin
        cnt_d = delay_ok ? cnt_q : cnt_inc;
        to_d = to_inc;
        if (delay_ok && ack_ok) begin
          state_d = last ? run_s : rel_s;
          stage_d = last ? stage_q : stage_q + 1'b1;
          cnt_d = '0;
          to_d = '0;
        end else if (to_hit) begin
          state_d = err_s;
        end
      end
      run_s: begin
        if (!calib) begin
          state_d = err_s;
          stage_d = '0;
        end
      end
      err_s: state_d = err_s;
      default: state_d = hold_s;
    endcase
    if (soft_reset_i) begin
      state_d = hold_s;
      stage_d = '0;
      cnt_d = '0;
      to_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= hold_s;
      stage_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      sync_q <= '0;
      reset_o <= '1;
      busy_o <= 1'b1;
      done_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      sync_q <= {sync_q[0], calib_done_i};
      reset_o <= (state_d == rel_s) ? rel_mask : (state_d == run_s) ? '0 : '1;
      busy_o <= state_d == hold_s || state_d == wait_s || state_d == rel_s;
      done_o <= state_d == run_s;
      error_o <= state_d == err_s;
    end
  end
`ifdef BP_RESET_SEQ_HEARTBEAT_EN
  localparam int hb_w_lp = $clog2(led_half_period_p + 1);
  logic [hb_w_lp-1:0] hb_cnt_q, hb_cnt_d;
  logic hb_d, hb_wrap, in_run;
  assign in_run = state_q == run_s && state_d == run_s;
  assign hb_wrap = hb_cnt_q == hb_w_lp'(led_half_period_p - 1);
  assign hb_cnt_d = (in_run && !hb_wrap) ? hb_cnt_q + 1'b1 : '0;
  assign hb_d = (state_d == err_s) ? 1'b1 : in_run ? heartbeat_o ^ hb_wrap : 1'b0;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hb_cnt_q <= '0;
      heartbeat_o <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      heartbeat_o <= hb_d;
    end
  end
`else
  assign heartbeat_o = 1'b0;
`endif
endmodule
